lcd_bus_reader: RTL and testbench

//  Read side of the HD44780 parallel interface; the write-path LCD peripheral only drives rs/e/data.
//  J1-bus memory-mapped block that runs an RW=1 read cycle on the character LCD.
//  Two read targets: busy flag + address counter (rs=0), or the DDRAM/CGRAM byte at the cursor (rs=1).

---
 rtl/lcd_bus_reader_pkg.sv | 55 +++++
 rtl/lcd_bus_reader_timer.sv | 40 ++++
 rtl/lcd_bus_reader.sv | 265 ++++++++++++++++++++++++++
 tb/tb_lcd_bus_reader.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_bus_reader_pkg.sv
// ---------------------------------------------------------------------------
// lcd_bus_reader_pkg
// Shared definitions for the HD44780 read-side peripheral and its companion
// write-path peripheral: register addresses, FSM state encoding, status bit
// positions and default timing constants.
// Optional feature macro used by the users of this package: LCD_RD_AUTOPOLL_EN.
// ---------------------------------------------------------------------------
package lcd_bus_reader_pkg;

  // Default timing in clk cycles (50 MHz clock)
  localparam int unsigned T_AS_DEF     = 3;
  localparam int unsigned T_EH_DEF     = 25;
  localparam int unsigned T_HOLD_DEF   = 2;
  localparam int unsigned POLL_MAX_DEF = 1000;

  // Register map
  localparam logic [3:0] ADDR_START  = 4'h0;
  localparam logic [3:0] ADDR_STATUS = 4'h1;
  localparam logic [3:0] ADDR_RESULT = 4'h2;
  localparam logic [3:0] ADDR_POLL   = 4'h3;

  // Status register bit positions
  localparam int unsigned STAT_ACTIVE_BIT = 0;
  localparam int unsigned STAT_DONE_BIT   = 1;

  // Busy-flag position inside an rs=0 read result
  localparam int unsigned BF_BIT = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_EHIGH = 2'd2,
    ST_HOLD  = 2'd3
  } rd_state_e;

  // Largest of three phase lengths; sizes the shared phase counter
  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) begin
      m = b;
    end else begin
      m = m;
    end
    if (c > m) begin
      m = c;
    end else begin
      m = m;
    end
    return m;
  endfunction

endpackage

// File: rtl/lcd_bus_reader_timer.sv
// ---------------------------------------------------------------------------
// lcd_rd_timer
// Loadable down-counter for the LCD read-cycle phases. Loading sets the
// phase length; the counter then steps down once per clock and parks at 1.
// o_term is high while the count is 1, i.e. during the last cycle of a phase.
// Ports:
//   clk        in  system clock
//   rst        in  asynchronous reset, active-low
//   i_load     in  load i_load_val on the next edge (phase entry)
//   i_load_val in  phase length in cycles (>= 1)
//   o_term     out last cycle of the current phase
// ---------------------------------------------------------------------------
module lcd_rd_timer #(
  parameter int unsigned W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_term
);

  logic [W-1:0] r_count;

  // Phase counter: reload on entry, count down to 1 and hold there
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count > W'(1)) begin
      r_count <= r_count - W'(1);
    end else begin
      r_count <= r_count;
    end
  end

  assign o_term = (r_count == W'(1));

endmodule

// File: rtl/lcd_bus_reader.sv
// ---------------------------------------------------------------------------
// lcd_bus_reader
// J1-bus peripheral that runs an HD44780 read cycle (rw=1). Target rs=0
// returns busy flag + address counter, rs=1 returns the DDRAM/CGRAM byte at
// the cursor. The surrounding top level hands the LCD data pads to this block
// whenever rw=1.
// Optional feature (macro LCD_RD_AUTOPOLL_EN): register 0x3 starts a busy-flag
// auto-poll that repeats rs=0 reads until bf=0 or POLL_MAX reads are done.
// Ports:
//   clk      in   system clock
//   rst      in   asynchronous reset, active-low
//   cs/addr/rd/wr/d_in  bus request; d_out registered read data
//   lcd_din  in   LCD data pads (sampled on the last e-high cycle)
//   rs/rw/e  out  LCD control, all registered
// Registers: 0x0 W start (d_in[0]=rs), 0x1 R {done,active},
//            0x2 R last byte read, 0x3 W/R auto-poll / {timeout}
// ---------------------------------------------------------------------------
module lcd_bus_reader
  import lcd_bus_reader_pkg::*;
#(
  parameter int unsigned T_AS     = T_AS_DEF,
  parameter int unsigned T_EH     = T_EH_DEF,
`ifdef LCD_RD_AUTOPOLL_EN
  parameter int unsigned POLL_MAX = POLL_MAX_DEF,
`endif
  parameter int unsigned T_HOLD   = T_HOLD_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs,
  input  logic [3:0]  addr,
  input  logic        rd,
  input  logic        wr,
  input  logic [15:0] d_in,
  output logic [15:0] d_out,
  input  logic [7:0]  lcd_din,
  output logic        rs,
  output logic        rw,
  output logic        e
);

  localparam int unsigned PH_W = $clog2(max3(T_AS, T_EH, T_HOLD) + 1);

  rd_state_e       r_state;
  rd_state_e       w_next_state;
  logic            w_load;
  logic [PH_W-1:0] w_load_val;
  logic            w_term;

  logic            w_start_acc;
  logic            w_poll_acc;
  logic            w_go;
  logic            w_repoll;
  logic            w_hold_exit;
  logic            w_active;
  logic [15:0]     w_poll_status;

  logic            r_target;
  logic            r_done;
  logic [7:0]      r_result;
  logic            r_rs;
  logic            r_rw;
  logic            r_e;
  logic [15:0]     r_d_out;

  // Only d_in[0] carries meaning; the rest of the write word is don't-care
  logic            w_unused;
  assign w_unused = ^d_in[15:1];

  assign w_start_acc = cs && wr && (addr == ADDR_START) && (r_state == ST_IDLE);
  assign w_go        = w_start_acc || w_poll_acc;
  assign w_hold_exit = (r_state == ST_HOLD) && w_term;
  assign w_active    = (r_state != ST_IDLE);

  lcd_rd_timer #(
    .W (PH_W)
  ) u_phase_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_term     (w_term)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next state and phase-counter reload on every state entry
  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_load_val   = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_go) begin
          w_next_state = ST_SETUP;
          w_load       = 1'b1;
          w_load_val   = PH_W'(T_AS);
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (w_term) begin
          w_next_state = ST_EHIGH;
          w_load       = 1'b1;
          w_load_val   = PH_W'(T_EH);
        end else begin
          w_next_state = ST_SETUP;
        end
      end
      ST_EHIGH: begin
        if (w_term) begin
          w_next_state = ST_HOLD;
          w_load       = 1'b1;
          w_load_val   = PH_W'(T_HOLD);
        end else begin
          w_next_state = ST_EHIGH;
        end
      end
      ST_HOLD: begin
        if (w_term && w_repoll) begin
          // Back-to-back poll read: rw stays high, e gets a fresh setup
          w_next_state = ST_SETUP;
          w_load       = 1'b1;
          w_load_val   = PH_W'(T_AS);
        end else if (w_term) begin
          w_next_state = ST_IDLE;
        end else begin
          w_next_state = ST_HOLD;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Read target latched on an accepted start; auto-poll always reads rs=0
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_target <= 1'b0;
    end else if (w_start_acc) begin
      r_target <= d_in[0];
    end else if (w_poll_acc) begin
      r_target <= 1'b0;
    end else begin
      r_target <= r_target;
    end
  end

  // LCD byte captured on the last e-high cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_result <= 8'h00;
    end else if ((r_state == ST_EHIGH) && w_term) begin
      r_result <= lcd_din;
    end else begin
      r_result <= r_result;
    end
  end

  // done: cleared by a start, set only when the sequence returns to IDLE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_done <= 1'b0;
    end else if (w_go) begin
      r_done <= 1'b0;
    end else if (w_hold_exit && !w_repoll) begin
      r_done <= 1'b1;
    end else begin
      r_done <= r_done;
    end
  end

  // LCD control pins, one cycle behind the state so e sits strictly inside rw
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rw <= 1'b0;
      r_rs <= 1'b0;
      r_e  <= 1'b0;
    end else begin
      r_rw <= (r_state != ST_IDLE);
      r_rs <= (r_state != ST_IDLE) ? r_target : 1'b0;
      r_e  <= (r_state == ST_EHIGH);
    end
  end

`ifdef LCD_RD_AUTOPOLL_EN
  localparam int unsigned PC_W = $clog2(POLL_MAX + 1);

  logic            r_poll;
  logic            r_timeout;
  logic [PC_W-1:0] r_poll_cnt;

  assign w_poll_acc    = cs && wr && (addr == ADDR_POLL) && d_in[0] && (r_state == ST_IDLE);
  assign w_repoll      = r_poll && r_result[BF_BIT] && (r_poll_cnt < PC_W'(POLL_MAX));
  assign w_poll_status = {15'h0000, r_timeout};

  // Poll session: counts completed reads; timeout if the last one is still busy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_poll     <= 1'b0;
      r_timeout  <= 1'b0;
      r_poll_cnt <= '0;
    end else if (w_start_acc) begin
      r_poll     <= 1'b0;
      r_timeout  <= 1'b0;
      r_poll_cnt <= r_poll_cnt;
    end else if (w_poll_acc) begin
      r_poll     <= 1'b1;
      r_timeout  <= 1'b0;
      r_poll_cnt <= PC_W'(1);
    end else if (w_hold_exit && w_repoll) begin
      r_poll     <= r_poll;
      r_timeout  <= r_timeout;
      r_poll_cnt <= r_poll_cnt + PC_W'(1);
    end else if (w_hold_exit && r_poll) begin
      r_poll     <= 1'b0;
      r_timeout  <= r_result[BF_BIT];
      r_poll_cnt <= r_poll_cnt;
    end else begin
      r_poll     <= r_poll;
      r_timeout  <= r_timeout;
      r_poll_cnt <= r_poll_cnt;
    end
  end
`else
  assign w_poll_acc    = 1'b0;
  assign w_repoll      = 1'b0;
  assign w_poll_status = 16'h0000;
`endif

  // Registered read data; captures pre-edge state so a same-cycle start is not seen
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_d_out <= 16'h0000;
    end else if (cs && rd) begin
      case (addr)
        ADDR_STATUS: begin
          r_d_out                  <= 16'h0000;
          r_d_out[STAT_DONE_BIT]   <= r_done;
          r_d_out[STAT_ACTIVE_BIT] <= w_active;
        end
        ADDR_RESULT: r_d_out <= {8'h00, r_result};
        ADDR_POLL:   r_d_out <= w_poll_status;
        default:     r_d_out <= 16'h0000;
      endcase
    end else begin
      r_d_out <= r_d_out;
    end
  end

  assign d_out = r_d_out;
  assign rs    = r_rs;
  assign rw    = r_rw;
  assign e     = r_e;

endmodule

// File: tb/tb_lcd_bus_reader.sv
// ---------------------------------------------------------------------------
// tb_lcd_bus_reader
// Directed self-checking bench for lcd_bus_reader. Auto-poll scenarios are
// built only when LCD_RD_AUTOPOLL_EN is defined (DUT then uses POLL_MAX=4).
// ---------------------------------------------------------------------------
module tb_lcd_bus_reader;
  import lcd_bus_reader_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cs = 1'b0;
  logic [3:0]  addr = 4'h0;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [15:0] d_in = 16'h0000;
  logic [15:0] d_out;
  logic [7:0]  lcd_din = 8'h00;
  logic        rs;
  logic        rw;
  logic        e;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  lcd_bus_reader #(
`ifdef LCD_RD_AUTOPOLL_EN
    .POLL_MAX (4),
`endif
    .T_AS     (3),
    .T_EH     (25),
    .T_HOLD   (2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .cs      (cs),
    .addr    (addr),
    .rd      (rd),
    .wr      (wr),
    .d_in    (d_in),
    .d_out   (d_out),
    .lcd_din (lcd_din),
    .rs      (rs),
    .rw      (rw),
    .e       (e)
  );

  // Pin monitor: pulse count, e-high length, setup/hold lengths, protocol violations
  int   e_pulses = 0;
  int   cur_len = 0;
  int   last_len = 0;
  int   as_cnt = 0;
  int   last_as = 0;
  int   last_hold = 0;
  int   viol_rw = 0;
  int   viol_rs = 0;
  logic prev_e = 1'b0;
  logic prev_rw = 1'b0;
  logic rs_at_e = 1'b0;

  always @(negedge clk) begin
    prev_e  <= e;
    prev_rw <= rw;
    if (e && !rw) viol_rw <= viol_rw + 1;
    if (e && prev_e && (rs !== rs_at_e)) viol_rs <= viol_rs + 1;
    if (e && !prev_e) begin
      e_pulses <= e_pulses + 1;
      rs_at_e  <= rs;
      last_as  <= as_cnt;
    end
    if (e) begin
      cur_len <= cur_len + 1;
    end else if (prev_e) begin
      last_len <= cur_len;
      cur_len  <= 0;
    end
    if (e) as_cnt <= 0;
    else if (rw) as_cnt <= as_cnt + 1;
    else as_cnt <= 0;
    if (!rw && prev_rw) last_hold <= as_cnt;
  end

  task automatic bus_write(input logic [3:0] a, input logic [15:0] v);
    @(negedge clk);
    cs = 1'b1; wr = 1'b1; addr = a; d_in = v;
    @(negedge clk);
    cs = 1'b0; wr = 1'b0; addr = 4'h0; d_in = 16'h0000;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [15:0] v);
    @(negedge clk);
    cs = 1'b1; rd = 1'b1; addr = a;
    @(negedge clk);
    cs = 1'b0; rd = 1'b0; addr = 4'h0;
    v = d_out;
  endtask

  task automatic wait_e(input logic lvl, input int budget, input string name);
    int n;
    n = 0;
    while ((e !== lvl) && (n < budget)) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (e !== lvl) begin
      fails++;
      $display("FAIL %s: e=%b after %0d cycles, required %b", name, e, n, lvl);
    end
  endtask

  task automatic wait_done(input int budget, input string name);
    logic [15:0] s;
    int n;
    n = 0;
    s = 16'h0000;
    while ((s[STAT_DONE_BIT] !== 1'b1) && (n < budget)) begin
      bus_read(ADDR_STATUS, s);
      n++;
    end
    tests++;
    if (s[STAT_DONE_BIT] !== 1'b1) begin
      fails++;
      $display("FAIL %s: status=%h after %0d reads, required done=1", name, s, n);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [15:0] v;
    repeat (3) @(negedge clk);
    tests++;
    if ({e, rw, rs} !== 3'b000 || d_out !== 16'h0000) begin
      fails++;
      $display("FAIL reset_pins: e/rw/rs=%b d_out=%h, required 000/0000", {e, rw, rs}, d_out);
    end
    rst = 1'b1;
    bus_read(ADDR_STATUS, v);
    tests++;
    if (v !== 16'h0000) begin
      fails++;
      $display("FAIL reset_status: got %h, required 0000", v);
    end
  endtask

  task automatic test_read_bf();
    logic [15:0] v;
    int p0;
    lcd_din = 8'h85;
    p0 = e_pulses;
    bus_write(ADDR_START, 16'h0000);
    wait_e(1'b1, 20, "bf_e_rise");
    tests++;
    if (rs !== 1'b0) begin
      fails++;
      $display("FAIL bf_rs: got %b, required 0", rs);
    end
    wait_done(100, "bf_done");
    tests++;
    if ((e_pulses - p0) !== 1 || last_len !== 25) begin
      fails++;
      $display("FAIL bf_pulse: pulses=%0d len=%0d, required 1/25", e_pulses - p0, last_len);
    end
    tests++;
    if (last_as !== 3 || last_hold !== 2) begin
      fails++;
      $display("FAIL bf_setup_hold: setup=%0d hold=%0d, required 3/2", last_as, last_hold);
    end
    bus_read(ADDR_RESULT, v);
    tests++;
    if (v !== 16'h0085) begin
      fails++;
      $display("FAIL bf_result: got %h, required 0085", v);
    end
    bus_read(ADDR_STATUS, v);
    tests++;
    if (v !== 16'h0002) begin
      fails++;
      $display("FAIL bf_status: got %h, required 0002", v);
    end
  endtask

  task automatic test_start_ignored();
    logic [15:0] v;
    int p0;
    lcd_din = 8'h41;
    p0 = e_pulses;
    bus_write(ADDR_START, 16'h0001);
    wait_e(1'b1, 20, "data_e_rise");
    bus_write(ADDR_START, 16'h0000);
    tests++;
    if (rs !== 1'b1 || rw !== 1'b1) begin
      fails++;
      $display("FAIL data_rs_rw: rs=%b rw=%b, required 1/1", rs, rw);
    end
    wait_done(100, "data_done");
    repeat (40) @(negedge clk);
    tests++;
    if ((e_pulses - p0) !== 1 || last_len !== 25) begin
      fails++;
      $display("FAIL data_single: pulses=%0d len=%0d, required 1/25", e_pulses - p0, last_len);
    end
    bus_read(ADDR_RESULT, v);
    tests++;
    if (v !== 16'h0041) begin
      fails++;
      $display("FAIL data_result: got %h, required 0041", v);
    end
  endtask

  task automatic test_other_addr();
    logic [15:0] v;
    int p0;
    bus_read(4'h7, v);
    tests++;
    if (v !== 16'h0000) begin
      fails++;
      $display("FAIL addr7_read: got %h, required 0000", v);
    end
`ifndef LCD_RD_AUTOPOLL_EN
    p0 = e_pulses;
    bus_write(ADDR_POLL, 16'h0001);
    repeat (40) @(negedge clk);
    bus_read(ADDR_POLL, v);
    tests++;
    if (v !== 16'h0000 || (e_pulses - p0) !== 0) begin
      fails++;
      $display("FAIL poll_disabled: read=%h pulses=%0d, required 0000/0", v, e_pulses - p0);
    end
`else
    p0 = 0;
`endif
    bus_read(ADDR_STATUS, v);
    tests++;
    if (v !== 16'h0002) begin
      fails++;
      $display("FAIL idle_status: got %h, required 0002", v);
    end
  endtask

  task automatic test_abort();
    logic [15:0] v;
    lcd_din = 8'h33;
    bus_write(ADDR_START, 16'h0001);
    wait_e(1'b1, 20, "abort_e_rise");
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    tests++;
    if ({e, rw, rs} !== 3'b000) begin
      fails++;
      $display("FAIL abort_pins: e/rw/rs=%b, required 000", {e, rw, rs});
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    bus_read(ADDR_STATUS, v);
    tests++;
    if (v !== 16'h0000) begin
      fails++;
      $display("FAIL abort_status: got %h, required 0000", v);
    end
    bus_read(ADDR_RESULT, v);
    tests++;
    if (v !== 16'h0000) begin
      fails++;
      $display("FAIL abort_result: got %h, required 0000", v);
    end
  endtask

  task automatic test_start_with_read();
    logic [15:0] v;
    lcd_din = 8'h07;
    @(negedge clk);
    cs = 1'b1; wr = 1'b1; rd = 1'b1; addr = ADDR_START; d_in = 16'h0000;
    @(negedge clk);
    cs = 1'b0; wr = 1'b0; rd = 1'b0; addr = 4'h0;
    v = d_out;
    tests++;
    if (v !== 16'h0000) begin
      fails++;
      $display("FAIL same_cycle_read: got %h, required 0000", v);
    end
    bus_read(ADDR_STATUS, v);
    tests++;
    if (v !== 16'h0001) begin
      fails++;
      $display("FAIL next_status: got %h, required 0001", v);
    end
    wait_done(100, "same_cycle_done");
  endtask

`ifdef LCD_RD_AUTOPOLL_EN
  task automatic test_autopoll();
    logic [15:0] v;
    int p0;
    lcd_din = 8'h92;
    p0 = e_pulses;
    bus_write(ADDR_POLL, 16'h0001);
    for (int k = 0; k < 3; k++) begin
      wait_e(1'b1, 60, "poll_rise");
      wait_e(1'b0, 60, "poll_fall");
    end
    lcd_din = 8'h12;
    wait_done(200, "poll_done");
    tests++;
    if ((e_pulses - p0) !== 4) begin
      fails++;
      $display("FAIL poll_pulses: got %0d, required 4", e_pulses - p0);
    end
    bus_read(ADDR_POLL, v);
    tests++;
    if (v !== 16'h0000) begin
      fails++;
      $display("FAIL poll_timeout: got %h, required 0000", v);
    end
    bus_read(ADDR_RESULT, v);
    tests++;
    if (v !== 16'h0012) begin
      fails++;
      $display("FAIL poll_result: got %h, required 0012", v);
    end
  endtask

  task automatic test_autopoll_timeout();
    logic [15:0] v;
    int p0;
    lcd_din = 8'hFF;
    p0 = e_pulses;
    bus_write(ADDR_POLL, 16'h0001);
    wait_done(200, "to_done");
    tests++;
    if ((e_pulses - p0) !== 4) begin
      fails++;
      $display("FAIL to_pulses: got %0d, required 4", e_pulses - p0);
    end
    bus_read(ADDR_POLL, v);
    tests++;
    if (v !== 16'h0001) begin
      fails++;
      $display("FAIL to_flag: got %h, required 0001", v);
    end
    lcd_din = 8'h00;
    bus_write(ADDR_START, 16'h0000);
    wait_done(100, "to_clear_done");
    bus_read(ADDR_POLL, v);
    tests++;
    if (v !== 16'h0000) begin
      fails++;
      $display("FAIL to_cleared: got %h, required 0000", v);
    end
  endtask
`endif

  task automatic test_protocol();
    tests++;
    if (viol_rw !== 0 || viol_rs !== 0) begin
      fails++;
      $display("FAIL protocol: e-without-rw=%0d rs-change=%0d, required 0/0", viol_rw, viol_rs);
    end
  endtask

  initial begin
    test_reset();
    test_read_bf();
    test_start_ignored();
    test_other_addr();
    test_abort();
    test_start_with_read();
`ifdef LCD_RD_AUTOPOLL_EN
    test_autopoll();
    test_autopoll_timeout();
`endif
    test_protocol();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
